psram_burst_writer: RTL
=======================

Name: psram_burst_writer

Overview:
Streaming write front-end for the Gowin PSRAM HS controller. Accepts a 64-bit valid/ready word stream, for example from the capture path, and buffers it in an internal FIFO. It then issues fixed-length write bursts (command plus BURST_WORDS data beats) to the controller at incrementing addresses. It sits directly upstream of the PSRAM controller's wr_data/addr/cmd/cmd_en/data_mask inputs.

Parameters:
BURST_WORDS, 16, 64-bit data beats per write command
ADDR_STEP, 32, psram address increment per burst
CMD_INTERVAL, 27, minimum sys_clk cycles from one cmd_en pulse to the next
FIFO_DEPTH, 32, input FIFO depth in words; power of two, at least 2*BURST_WORDS
ADDR_LIMIT, 21'h1FFFE0, first address at or beyond which the write pointer wraps to base

Ports:
sys_clk  in  1  system clock; the controller user clock (84 MHz)
sys_rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches base_addr and arms the writer
base_addr  in  21  start address of the region
s_data  in  64  stream word
s_valid  in  1  stream word valid
s_ready  out  1  FIFO can accept a word
flush  in  1  one-cycle pulse; write out a partial burst padded with masked beats
psram_init_calib  in  1  controller calibration done
psram_cmd  out  1  1 = write; this block only ever drives 1 while cmd_en is high
psram_cmd_en  out  1  one-cycle command strobe
psram_addr  out  21  burst address; valid while psram_cmd_en is high
psram_wr_data  out  64  beat data
psram_data_mask  out  8  per-byte mask; 1 = byte not written
busy  out  1  armed, or a burst is in progress
flush_done  out  1  one-cycle pulse when a flush completes
burst_count  out  16  bursts issued since start; wraps at 2^16

Behaviour:
- Reset: all outputs 0. State IDLE. FIFO empty. Address register 0. burst_count 0.
- The already-decided clock/reset scheme applies: one clock sys_clk; sys_rst_n is asynchronous and active-low. There is no synchronous clear except start.
- All outputs are registered.
- s_ready = (fifo_count < FIFO_DEPTH). A word is accepted when s_valid && s_ready.
- The FIFO is written only while busy=1. Words offered while busy=0 are accepted and discarded.
- States:
  - IDLE: wait for start. On start: wr_addr <= base_addr, base_reg <= base_addr, burst_count <= 0, FIFO cleared, busy <= 1, go to WAIT_CAL.
  - WAIT_CAL: wait for psram_init_calib=1, then go to ARMED.
  - ARMED: leave when fifo_count >= BURST_WORDS, or when flush_pending and fifo_count > 0, provided the gap counter has expired. Go to BURST.
  - BURST: runs BURST_WORDS cycles, beat index k = 0..BURST_WORDS-1.
    - Beat 0: psram_cmd=1, psram_cmd_en=1, psram_addr=wr_addr, plus data for beat 0. Command and first data beat share the same cycle.
    - Beats 1..BURST_WORDS-1: one beat per consecutive cycle, cmd_en=0.
    - A beat with a FIFO word: pop it, data_mask=8'h00.
    - Padding beat (partial flush only): data 0, data_mask=8'hFF.
    - After the last beat: burst_count+1; wr_addr <= wr_addr+ADDR_STEP, or base_reg if that sum >= ADDR_LIMIT; return to ARMED.
- Gap counter: loaded to CMD_INTERVAL-1 on each cmd_en and decremented each cycle. The next cmd_en is never sooner than CMD_INTERVAL cycles after the previous one.
- Outside BURST: psram_wr_data=0, psram_data_mask=0, psram_cmd_en=0.
- Flush:
  - A flush pulse in any state other than IDLE sets flush_pending. A flush in IDLE is ignored.
  - In ARMED with flush_pending and fifo_count==0: pulse flush_done, clear flush_pending, clear busy, go to IDLE.
  - Full bursts still in the FIFO drain first.
  - A flush while flush_pending is already set is absorbed (no extra effect).
- Words arriving during a flush drain are still accepted and written ahead of the completion.
- start while busy=1 is ignored.
- If reset asserts mid-burst, the burst is abandoned immediately with all outputs 0. The controller side is recovered by the controller's own reset on the shared rst_n.
- Simultaneous push and pop in the same cycle: fifo_count is unchanged.
- The FIFO never overflows; s_ready enforces this.
- The FIFO never underflows: a burst starts only when its words are present, or it is a padded flush burst.

Test Plan:
- Reset, start with base 0, calib high, push 16 words 0..15 back-to-back: one cmd_en at addr 0; wr_data 0..15 on 16 consecutive cycles starting with the cmd_en cycle; mask 0; burst_count=1.
- Push 48 words continuously: cmd_en at addrs 0, 32, 64; consecutive cmd_en pulses exactly 27 cycles apart; s_ready drops while FIFO holds 32 words.
- Push 5 words, then flush: one burst with beats 0..4 = data and mask 00, beats 5..15 = data 0 and mask FF; flush_done pulses after the last beat; busy=0.
- base_addr=21'h1FFFC0, push 48 words: addresses 1FFFC0, then base 1FFFC0 again, because 1FFFE0 >= ADDR_LIMIT triggers the wrap.
- Words pushed with calib low: no cmd_en until calib rises, then bursts issue. Flush with an empty FIFO: flush_done one cycle later, no cmd_en.
- Assert sys_rst_n low at beat 7 of a burst: all outputs 0 asynchronously; after release, state IDLE and burst_count 0.

Source files
------------

// File: rtl/psram_burst_writer_if.sv
// Stream input and PSRAM controller write-side signals of the burst writer.
interface psram_burst_writer_if;
    logic [63:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        psram_init_calib;
    logic        psram_cmd;
    logic        psram_cmd_en;
    logic [20:0] psram_addr;
    logic [63:0] psram_wr_data;
    logic [7:0]  psram_data_mask;

    // Burst writer side: consumes the stream, drives the controller
    modport master (
        input  s_data, s_valid, psram_init_calib,
        output s_ready, psram_cmd, psram_cmd_en, psram_addr, psram_wr_data, psram_data_mask
    );

    // Environment side: stream producer and PSRAM controller
    modport slave (
        output s_data, s_valid, psram_init_calib,
        input  s_ready, psram_cmd, psram_cmd_en, psram_addr, psram_wr_data, psram_data_mask
    );
endinterface

// File: rtl/psram_burst_writer.sv
// psram_burst_writer: buffers a 64-bit word stream in a FIFO and writes it to
// the Gowin PSRAM HS controller as fixed-length bursts at incrementing
// addresses, with a flush that pads the last partial burst with masked beats.
module psram_burst_writer #(
    parameter int          BURST_WORDS  = 16,
    parameter int          ADDR_STEP    = 32,
    parameter int          CMD_INTERVAL = 27,
    parameter int          FIFO_DEPTH   = 32,
    parameter logic [20:0] ADDR_LIMIT   = 21'h1FFFE0
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 start,
    input  logic [20:0]          base_addr,
    input  logic                 flush,
    output logic                 busy,
    output logic                 flush_done,
    output logic [15:0]          burst_count,
    psram_burst_writer_if.master bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = $clog2(BURST_WORDS) + 1;
    localparam int GAP_W  = $clog2(CMD_INTERVAL) + 1;

    localparam logic [BEAT_W-1:0] BEATS       = BEAT_W'(BURST_WORDS);
    localparam logic [CNT_W-1:0]  CNT_BURST   = CNT_W'(BURST_WORDS);
    localparam logic [CNT_W-1:0]  CNT_DEPTH   = CNT_W'(FIFO_DEPTH);
    localparam logic [GAP_W-1:0]  GAP_LOAD    = GAP_W'(CMD_INTERVAL - 1);
    localparam logic [21:0]       ADDR_STEP_W = 22'(ADDR_STEP);
    localparam logic [21:0]       LIMIT_W     = {1'b0, ADDR_LIMIT};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_CAL = 2'd1,
        ARMED    = 2'd2,
        BURST    = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [63:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  fifo_count, count_nxt;
    logic [BEAT_W-1:0] beat_idx;     // beats already placed on the output registers
    logic [BEAT_W-1:0] burst_fill;   // beats of the current burst that carry FIFO words
    logic [GAP_W-1:0]  gap_cnt;
    logic              flush_pending;
    logic [20:0]       wr_addr, base_reg;
    logic [21:0]       addr_sum;

    logic              start_go, push, pop, launch, burst_end, flush_complete;
    logic              pending_eff, cnt_ge_burst;
    logic [BEAT_W-1:0] fill_now, beat_p0, fill_p0;
    logic              vld_p0;
    logic              cmd_en_p0, busy_p0, flush_done_p0, s_ready_p0;
    logic [20:0]       addr_p0;
    logic [63:0]       data_p0;
    logic [7:0]        mask_p0;

    // Control decode shared by the FSM, the FIFO and the output stage.
    // A flush arriving this cycle counts as pending so an empty flush completes at once.
    always_comb begin
        start_go       = (state == IDLE) && start;
        pending_eff    = flush_pending || (flush && (state != IDLE));
        cnt_ge_burst   = (fifo_count >= CNT_BURST);
        fill_now       = cnt_ge_burst ? BEATS : BEAT_W'(fifo_count);
        launch         = (state == ARMED) && (gap_cnt == '0) &&
                         (cnt_ge_burst || (pending_eff && (fifo_count != '0)));
        flush_complete = (state == ARMED) && pending_eff && (fifo_count == '0);
        burst_end      = (state == BURST) && (beat_idx == BEATS);
        vld_p0         = launch || ((state == BURST) && (beat_idx != BEATS));
        beat_p0        = launch ? '0 : beat_idx;
        fill_p0        = launch ? fill_now : burst_fill;
        pop            = vld_p0 && (beat_p0 < fill_p0);
        push           = bus.s_valid && bus.s_ready && (state != IDLE);
        addr_sum       = {1'b0, wr_addr} + ADDR_STEP_W;
    end

    // FIFO occupancy after this cycle; start empties the FIFO
    always_comb begin
        count_nxt = fifo_count;
        if (start_go) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = fifo_count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = fifo_count - CNT_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_go) state_nxt = WAIT_CAL;
            WAIT_CAL: if (bus.psram_init_calib) state_nxt = ARMED;
            ARMED: begin
                if (flush_complete) begin
                    state_nxt = IDLE;
                end else if (launch) begin
                    state_nxt = BURST;
                end
            end
            BURST:    if (burst_end) state_nxt = ARMED;
            default:  state_nxt = IDLE;
        endcase
    end

    // FSM output logic: next values for the registered controller-side outputs.
    // Command and beat 0 share a cycle; beats past the fill are masked padding.
    always_comb begin
        cmd_en_p0     = 1'b0;
        addr_p0       = '0;
        data_p0       = '0;
        mask_p0       = '0;
        if (launch) begin
            cmd_en_p0 = 1'b1;
            addr_p0   = wr_addr;
        end
        if (vld_p0) begin
            if (pop) begin
                data_p0 = fifo_mem[rd_ptr];
            end else begin
                mask_p0 = 8'hFF;
            end
        end
        busy_p0       = (state_nxt != IDLE);
        flush_done_p0 = flush_complete;
        s_ready_p0    = (count_nxt < CNT_DEPTH);
    end

    // ---- output register stage ----
    // Registered outputs; reset forces every output to 0 immediately
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bus.psram_cmd       <= 1'b0;
            bus.psram_cmd_en    <= 1'b0;
            bus.psram_addr      <= '0;
            bus.psram_wr_data   <= '0;
            bus.psram_data_mask <= '0;
            bus.s_ready         <= 1'b0;
            busy                <= 1'b0;
            flush_done          <= 1'b0;
        end else begin
            bus.psram_cmd       <= cmd_en_p0;
            bus.psram_cmd_en    <= cmd_en_p0;
            bus.psram_addr      <= addr_p0;
            bus.psram_wr_data   <= data_p0;
            bus.psram_data_mask <= mask_p0;
            bus.s_ready         <= s_ready_p0;
            busy                <= busy_p0;
            flush_done          <= flush_done_p0;
        end
    end

    // FIFO pointers, burst sequencing, command gap, address walk and flush tracking
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            fifo_count    <= '0;
            beat_idx      <= '0;
            burst_fill    <= '0;
            gap_cnt       <= '0;
            flush_pending <= 1'b0;
            wr_addr       <= '0;
            base_reg      <= '0;
            burst_count   <= '0;
        end else begin
            fifo_count <= count_nxt;
            if (start_go) begin
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                gap_cnt     <= '0;
                wr_addr     <= base_addr;
                base_reg    <= base_addr;
                burst_count <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (launch) begin
                    gap_cnt <= GAP_LOAD;
                end else if (gap_cnt != '0) begin
                    gap_cnt <= gap_cnt - GAP_W'(1);
                end
                if (burst_end) begin
                    burst_count <= burst_count + 16'd1;
                    wr_addr     <= (addr_sum >= LIMIT_W) ? base_reg : addr_sum[20:0];
                end
            end
            if (launch) begin
                beat_idx   <= BEAT_W'(1);
                burst_fill <= fill_now;
            end else if ((state == BURST) && (beat_idx != BEATS)) begin
                beat_idx <= beat_idx + BEAT_W'(1);
            end
            if (start_go || flush_complete) begin
                flush_pending <= 1'b0;
            end else if (flush && (state != IDLE)) begin
                flush_pending <= 1'b1;
            end
        end
    end

    // FIFO storage write port; contents need no reset
    always_ff @(posedge sys_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.s_data;
        end
    end
endmodule
